// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// input glitch-filter length, frame bit-index constants and the parity
// helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_RELEASE
  } state_t;

  // A pad level must be seen this many consecutive samples before the
  // filtered level follows it.
  localparam int FILTER_LEN = 8;

  // Bit indexes within the frame after the start bit:
  // 0..7 data, 8 parity, 9 stop, 10 = waiting for the device acknowledge.
  localparam logic [3:0] IDX_PARITY = 4'd8;
  localparam logic [3:0] IDX_STOP   = 4'd9;
  localparam logic [3:0] IDX_ACK    = 4'd10;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Request/status handshake between a command source and the PS/2 host
// transmitter.
//   strb  : one-cycle request to send data
//   data  : byte to send, sampled with an accepted strb
//   busy  : transmitter owns the bus
//   done  : one-cycle pulse, frame acknowledged by the device
//   error : one-cycle pulse, timeout or missing acknowledge
// master = command source, slave = transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic       strb;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output strb, output data, input busy, input done, input error);
  modport slave  (input strb, input data, output busy, output done, output error);
endinterface

// File: rtl/ps2_filter.sv
// ---------------------------------------------------------------------------
// ps2_filter
// Two-flop synchroniser followed by a persistence filter for one PS/2 pad.
//   clock : system clock
//   reset : synchronous active-high reset, all flops go to 1 (idle bus)
//   pad   : asynchronous pad input
//   level : filtered level, follows pad only after FILTER_LEN equal samples
// ---------------------------------------------------------------------------
module ps2_filter
  import ps2_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter tracks how long the synchronised input has disagreed with
  // the filtered level; any agreeing sample restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts start/data/parity/stop on device clock falling edges, checks the
// device acknowledge and waits for the bus to go idle.
//   clock, reset : system clock, synchronous active-high reset
//   host         : strb/data request, busy/done/error status (slave side)
//   ps2CkI/DQI   : asynchronous pad inputs
//   ps2CkO/DQO   : open-drain drives, 0 pulls the line low, 1 releases it
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_KHZ    = 32000,
  parameter int INHIBIT_US = 110,
  parameter int TIMEOUT_MS = 15
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  input  logic         ps2CkI,
  input  logic         ps2DQI,
  output logic         ps2CkO,
  output logic         ps2DQO
);

  localparam int INH_CYC = INHIBIT_US * CLK_KHZ / 1000;
  localparam int TO_CYC  = TIMEOUT_MS * CLK_KHZ;
  localparam int INH_W   = $clog2(INH_CYC) + 1;
  localparam int TO_W    = $clog2(TO_CYC) + 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INH_CYC - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  logic ck_filt;
  logic dq_filt;
  logic ck_prev;
  logic fall;

  state_t           state, state_n;
  logic [INH_W-1:0] inh_cnt, inh_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic [3:0]       idx, idx_n;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic             ck_q, ck_n;
  logic             dq_q, dq_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             error_q, error_n;
  logic             active;

  ps2_filter u_ck_filter (.clock(clock), .reset(reset), .pad(ps2CkI), .level(ck_filt));
  ps2_filter u_dq_filter (.clock(clock), .reset(reset), .pad(ps2DQI), .level(dq_filt));

  // Registered falling-edge detect on the filtered device clock.
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_prev <= 1'b1;
      fall    <= 1'b0;
    end else begin
      ck_prev <= ck_filt;
      fall    <= ck_prev & ~ck_filt;
    end
  end

  // Line value for a given frame position: data bits, parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic p, input logic [3:0] i);
    if (i < IDX_PARITY) return b[i[2:0]];
    else if (i == IDX_PARITY) return p;
    else return 1'b1;
  endfunction

  assign active = (state == ST_START) || (state == ST_BITS) ||
                  (state == ST_ACK)   || (state == ST_RELEASE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      inh_cnt <= '0;
      to_cnt  <= '0;
      idx     <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      ck_q    <= 1'b1;
      dq_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_n;
      inh_cnt <= inh_n;
      to_cnt  <= to_n;
      idx     <= idx_n;
      byte_q  <= byte_n;
      par_q   <= par_n;
      ck_q    <= ck_n;
      dq_q    <= dq_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      error_q <= error_n;
    end
  end

  // Line drives are registered, so every value computed here appears on
  // the pads one cycle later; the start bit is therefore prepared one
  // cycle early so it is already low on the last inhibit cycle.
  always_comb begin
    state_n = state;
    inh_n   = inh_cnt;
    to_n    = to_cnt;
    idx_n   = idx;
    byte_n  = byte_q;
    par_n   = par_q;
    ck_n    = ck_q;
    dq_n    = dq_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    error_n = 1'b0;

    if (active && (to_cnt != '1)) to_n = to_cnt + TO_W'(1);

    unique case (state)
      ST_IDLE: begin
        ck_n   = 1'b1;
        dq_n   = 1'b1;
        busy_n = 1'b0;
        if (host.strb) begin
          byte_n  = host.data;
          par_n   = odd_parity(host.data);
          busy_n  = 1'b1;
          ck_n    = 1'b0;
          inh_n   = '0;
          state_n = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt != '1) inh_n = inh_cnt + INH_W'(1);
        if (inh_cnt == INH_PRE) dq_n = 1'b0;
        if (inh_cnt == INH_LAST) begin
          ck_n    = 1'b1;
          dq_n    = 1'b0;
          to_n    = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (fall) begin
          dq_n    = byte_q[0];
          idx_n   = '0;
          state_n = ST_BITS;
        end
      end
      ST_BITS: begin
        if (fall) begin
          if (idx == IDX_STOP) begin
            idx_n   = IDX_ACK;
            state_n = ST_ACK;
          end else begin
            idx_n = idx + 4'd1;
            dq_n  = frame_bit(byte_q, par_q, idx + 4'd1);
          end
        end
      end
      ST_ACK: begin
        if (dq_filt) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          ck_n    = 1'b1;
          dq_n    = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (ck_filt && dq_filt) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Timeout wins over anything else finishing in the same cycle, so
    // exactly one of done/error can ever pulse.
    if (active && (to_cnt == TO_LAST)) begin
      done_n  = 1'b0;
      error_n = 1'b1;
      busy_n  = 1'b0;
      ck_n    = 1'b1;
      dq_n    = 1'b1;
      state_n = ST_IDLE;
    end
  end

  assign ps2CkO     = ck_q;
  assign ps2DQO     = dq_q;
  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.error = error_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_KHZ, default 32000, system clock frequency in kHz.
REQ-002 Parameter INHIBIT_US, default 110, clock-line hold-low time before the request-to-send, in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15, maximum frame duration from the end of inhibit to the acknowledge, in milliseconds.
REQ-004 clock  in  1  system clock; all logic runs on its rising edge. One clock only; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 strb  in  1  one-cycle request to send the byte on data.
REQ-007 data  in  8  byte to transmit (command to the keyboard or mouse), sampled when strb is accepted.
REQ-008 busy  out  1  high from the accepted strb until done or error.
REQ-009 done  out  1  one-cycle pulse: frame sent and acknowledged by the device.
REQ-010 error  out  1  one-cycle pulse: timeout or missing acknowledge.
REQ-011 ps2CkI  in  1  PS/2 clock pad input, asynchronous.
REQ-012 ps2DQI  in  1  PS/2 data pad input, asynchronous.
REQ-013 ps2CkO  out  1  PS/2 clock drive; 0 pulls the line low, 1 releases it (open drain).
REQ-014 ps2DQO  out  1  PS/2 data drive; 0 pulls the line low, 1 releases it (open drain).

Function
REQ-015 ps2CkI and ps2DQI SHALL be synchronised through 2 flops, then filtered: the filtered level changes only after 8 consecutive equal samples.
REQ-016 A device clock falling edge is defined as filtered clock going 1 to 0; detection SHALL be registered, with 1 cycle of latency after the filter.
REQ-017 States: IDLE, INHIBIT, START, BITS, ACK, RELEASE. Transitions are listed in REQ-018 to REQ-023.
REQ-018 IDLE: when strb=1, latch data, compute odd parity (~^data), set busy, and go to INHIBIT on the next cycle. strb is ignored while busy=1.
REQ-019 INHIBIT: ps2CkO=0 and ps2DQO=1 for INHIBIT_US*CLK_KHZ/1000 cycles. On the final cycle, drive ps2DQO=0 (start bit), go to START, and start the timeout counter.
REQ-020 START: release ps2CkO=1 and keep ps2DQO=0. The first device falling edge presents data bit 0 and moves to BITS with bit index 0.
REQ-021 BITS: each following falling edge advances the index. Indexes 1..7 present data[1..7], index 8 presents parity, and index 9 releases ps2DQO=1 (stop). The falling edge after the stop goes to ACK.
REQ-022 ACK: sample the filtered data line at that falling edge. If 0, go to RELEASE. If 1, pulse error and return to IDLE.
REQ-023 RELEASE: wait until the filtered clock and the filtered data are both 1. Then pulse done, clear busy, and return to IDLE.
REQ-024 Data SHALL be placed on ps2DQO within 2 cycles of the falling edge being detected. Data SHALL never change on a rising edge.
REQ-025 The timeout counter runs from START to RELEASE exit. Reaching TIMEOUT_MS*CLK_KHZ cycles SHALL pulse error, release both lines, and return to IDLE.
REQ-026 done and error SHALL be mutually exclusive. Each is exactly 1 cycle wide, in the same cycle that busy falls.
REQ-027 Counter widths are $clog2 of the terminal count plus 1. Counters saturate and never wrap.
REQ-028 A spurious falling edge in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-029 On reset=1: state=IDLE, ps2CkO=1, ps2DQO=1, busy=0, done=0, error=0, all counters 0, synchroniser and filter flops 1.
REQ-030 Reset asserted mid-frame SHALL release both lines on the next cycle, with no done or error pulse.

Structure
REQ-031 The state encoding, the filter length and the ACK/stop bit-index constants SHALL live in shared package ps2_pkg.
REQ-032 The synchroniser and filter SHALL be sub-module ps2_filter, instanced twice (clock and data).
REQ-033 The block SHALL contain no tristates; the board top forms the pad as inout = O ? 1'bz : 1'b0.

Verification
REQ-034 strb with data=8'hF4 and a device model clocking at 12.5 kHz -> the model receives start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1, then drives ACK -> done pulses once and busy falls.
REQ-035 data=8'hED -> parity bit=1; data=8'h00 -> parity bit=1; data=8'hFF -> parity bit=1.
REQ-036 ps2CkO stays low for at least 3520 cycles (110 us at 32 MHz) before the clock is released with ps2DQO=0.
REQ-037 The device model never clocks after inhibit -> error pulses after 480000 cycles, both lines are released, and busy=0.
REQ-038 The device withholds ACK (data stays 1 on edge 11) -> error pulses and done does not.
REQ-039 reset during BITS at index 4 -> ps2CkO=ps2DQO=1 the next cycle; a new strb afterwards completes normally.
